// File: rtl/simple_single_cpu.sv
// simple_single_cpu: single-cycle 32-bit MIPS-subset core (PC, IM, RF, ALU, DM).
// Optional feature macro MUL_EN builds the multiplier for funct 011000 (mul).

module pc_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_in_i,
  output logic [31:0] pc_out_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i) pc_out_o <= '0;
    else       pc_out_o <= pc_in_i;
  end
endmodule

// Contents are preloaded from outside; the core only ever reads it.
module instr_mem #(
  parameter int IM_WORDS = 32
) (
  input  logic [$clog2(IM_WORDS)-1:0] addr_i,
  output logic [31:0]                 instr_o
);
  logic [31:0] Instr_Mem [0:IM_WORDS-1];

  assign instr_o = Instr_Mem[addr_i];
endmodule

module reg_file #(
  parameter int SP_INIT = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_en_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o
);
  logic [31:0] Reg_File [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) Reg_File[i] <= (i == 29) ? 32'(SP_INIT) : 32'd0;
    end else if (wr_en_i && (wr_addr_i != 5'd0)) begin
      Reg_File[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs_data_o = (rs_addr_i == 5'd0) ? 32'd0 : Reg_File[rs_addr_i];
  assign rt_data_o = (rt_addr_i == 5'd0) ? 32'd0 : Reg_File[rt_addr_i];
endmodule

// Little-endian word view: memory[k] holds bytes 4k+3..4k.
module data_mem #(
  parameter int DM_BYTES = 128
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [$clog2(DM_BYTES)-3:0]  addr_i,
  input  logic                         wr_en_i,
  input  logic [31:0]                  wr_data_i,
  output logic [31:0]                  rd_data_o
);
  logic [31:0] memory [0:DM_BYTES/4-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DM_BYTES/4; k++) memory[k] <= 32'd0;
    end else if (wr_en_i) begin
      memory[addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = memory[addr_i];
endmodule

module simple_single_cpu #(
  parameter int IM_WORDS = 32,
  parameter int DM_BYTES = 128,
  parameter int SP_INIT  = 128
) (
  input  logic clk_i,
  input  logic rst_i
);
  localparam int IM_AW = $clog2(IM_WORDS);
  localparam int DM_AW = $clog2(DM_BYTES);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_ORI  = 6'b001101,
                         OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                         OP_BEQ   = 6'b000100, OP_BGT  = 6'b000111, OP_BNEZ = 6'b000101,
                         OP_BGEZ  = 6'b000001, OP_J    = 6'b000010, OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000, FN_SUB  = 6'b100010, FN_AND = 6'b100100,
                         FN_OR   = 6'b100101, FN_SLT  = 6'b101010, FN_SLLV = 6'b000100,
                         FN_SLL  = 6'b000000, FN_SRLV = 6'b000110, FN_SRL = 6'b000010,
                         FN_MUL  = 6'b011000, FN_JR   = 6'b001000;

  logic [31:0] pc, pc_next, pc_plus4, br_target, jmp_target;
  logic [31:0] instr, rs_val, rt_val, wr_data, dm_rdata;
  logic [31:0] imm_s, imm_z, alu_sum;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wr_addr;
  logic        rf_we, dm_we;

  pc_reg PC (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pc_in_i  (pc_next),
    .pc_out_o (pc)
  );

  instr_mem #(.IM_WORDS(IM_WORDS)) IM (
    .addr_i  (pc[IM_AW+1:2]),
    .instr_o (instr)
  );

  reg_file #(.SP_INIT(SP_INIT)) RF (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_en_i   (rf_we),
    .rs_data_o (rs_val),
    .rt_data_o (rt_val)
  );

  // alu_sum doubles as the addi result and the load/store byte address.
  data_mem #(.DM_BYTES(DM_BYTES)) DM (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (alu_sum[DM_AW-1:2]),
    .wr_en_i   (dm_we),
    .wr_data_i (rt_val),
    .rd_data_o (dm_rdata)
  );

  assign opcode     = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rd         = instr[15:11];
  assign shamt      = instr[10:6];
  assign funct      = instr[5:0];
  assign imm_s      = {{16{instr[15]}}, instr[15:0]};
  assign imm_z      = {16'd0, instr[15:0]};
  assign alu_sum    = rs_val + imm_s;
  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {imm_s[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    wr_addr = rd;
    wr_data = 32'd0;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rf_we = 1'b1;
        case (funct)
          FN_ADD:  wr_data = rs_val + rt_val;
          FN_SUB:  wr_data = rs_val - rt_val;
          FN_AND:  wr_data = rs_val & rt_val;
          FN_OR:   wr_data = rs_val | rt_val;
          FN_SLT:  wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLLV: wr_data = rt_val << rs_val[4:0];
          FN_SLL:  wr_data = rt_val << shamt;
          FN_SRLV: wr_data = rt_val >> rs_val[4:0];
          FN_SRL:  wr_data = rt_val >> shamt;
`ifdef MUL_EN
          FN_MUL:  wr_data = rs_val * rt_val;
`endif
          FN_JR: begin
            rf_we   = 1'b0;
            pc_next = rs_val;
          end
          default: rf_we = 1'b0;
        endcase
      end
      OP_ADDI: begin wr_addr = rt; wr_data = alu_sum;         rf_we = 1'b1; end
      OP_ORI:  begin wr_addr = rt; wr_data = rs_val | imm_z;  rf_we = 1'b1; end
      OP_LUI:  begin wr_addr = rt; wr_data = imm_z;           rf_we = 1'b1; end
      OP_LW:   begin wr_addr = rt; wr_data = dm_rdata;        rf_we = 1'b1; end
      OP_SW:   dm_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_next = br_target;
      OP_BGT:  if (rs_val > rt_val)  pc_next = br_target;
      OP_BNEZ: if (rs_val != 32'd0)  pc_next = br_target;
      OP_BGEZ: if (!rs_val[31])      pc_next = br_target;
      OP_J:    pc_next = jmp_target;
      OP_JAL: begin
        pc_next = jmp_target;
        wr_addr = 5'd31;
        wr_data = pc_plus4;
        rf_we   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_simple_single_cpu.sv
// Directed bench for simple_single_cpu: programs are preloaded into IM, expected
// architectural state is queued and then compared against hierarchical state.
module tb_simple_single_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  simple_single_cpu dut (
    .clk_i (clk_i),
    .rst_i (rst_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    int          kind;   // 0 reg, 1 DM word, 2 PC
    int          idx;
    logic [31:0] val;
  } chk_t;

  chk_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] prog [0:31];

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(logic [5:0] op, int target);
    return {op, 26'(target)};
  endfunction

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      0:       return dut.RF.Reg_File[idx];
      1:       return dut.DM.memory[idx];
      default: return dut.PC.pc_out_o;
    endcase
  endfunction

  task automatic push(string tag, int kind, int idx, logic [31:0] val);
    chk_t c;
    c.tag = tag; c.kind = kind; c.idx = idx; c.val = val;
    sb.push_back(c);
  endtask

  task automatic exp_reg(int r, logic [31:0] v);
    push($sformatf("r%0d", r), 0, r, v);
  endtask
  task automatic exp_mem(int k, logic [31:0] v);
    push($sformatf("mem[%0d]", k), 1, k, v);
  endtask
  task automatic exp_pc(logic [31:0] v);
    push("pc", 2, 0, v);
  endtask

  task automatic check_all();
    chk_t        c;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      c   = sb.pop_front();
      obs = observe(c.kind, c.idx);
      total++;
      assert (obs === c.val) else begin
        bad++;
        $error("FAIL %s: got %h want %h", c.tag, obs, c.val);
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 32'd0;
  endtask

  // Load prog into IM while reset is held for two edges, then release.
  task automatic load_and_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] = prog[i];
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic step_pc(logic [31:0] pc_exp);
    step(1);
    exp_pc(pc_exp);
    check_all();
  endtask

  initial begin
    // Reset state
    clear_prog();
    load_and_reset();
    exp_pc(32'd0);
    for (int r = 0; r < 32; r++) exp_reg(r, (r == 29) ? 32'd128 : 32'd0);
    for (int k = 0; k < 32; k++) exp_mem(k, 32'd0);
    check_all();

    // ALU chain
    clear_prog();
    prog[0]  = enc_i(6'b001000, 0, 1, 5);
    prog[1]  = enc_i(6'b001000, 0, 2, -3);
    prog[2]  = enc_r(1, 2, 3, 0, 6'b100000);
    prog[3]  = enc_r(1, 2, 4, 0, 6'b100010);
    prog[4]  = enc_r(2, 1, 5, 0, 6'b101010);
    prog[5]  = enc_r(0, 1, 6, 2, 6'b000000);
    prog[6]  = enc_r(0, 6, 7, 1, 6'b000010);
    prog[7]  = enc_r(1, 2, 8, 0, 6'b101010);
    prog[8]  = enc_r(1, 2, 9, 0, 6'b100100);
    prog[9]  = enc_r(1, 2, 10, 0, 6'b100101);
    prog[10] = enc_r(1, 1, 11, 0, 6'b000100);
    prog[11] = enc_r(1, 2, 12, 0, 6'b000110);
    load_and_reset();
    for (int k = 1; k <= 12; k++) step_pc(32'(4 * k));
    exp_reg(1, 32'd5);        exp_reg(2, 32'hFFFF_FFFD);
    exp_reg(3, 32'd2);        exp_reg(4, 32'd8);
    exp_reg(5, 32'd1);        exp_reg(6, 32'd20);
    exp_reg(7, 32'd10);       exp_reg(8, 32'd0);
    exp_reg(9, 32'd5);        exp_reg(10, 32'hFFFF_FFFD);
    exp_reg(11, 32'hA0);      exp_reg(12, 32'h07FF_FFFF);
    check_all();

    // Branches
    clear_prog();
    prog[0]  = enc_i(6'b001000, 0, 1, 3);
    prog[1]  = enc_i(6'b001000, 0, 2, 3);
    prog[2]  = enc_i(6'b001000, 0, 3, -1);
    prog[3]  = enc_i(6'b001000, 0, 4, 0);
    prog[4]  = enc_i(6'b000100, 1, 2, 2);
    prog[5]  = enc_i(6'b001000, 0, 9, 'h99);
    prog[6]  = enc_i(6'b001000, 0, 9, 'h99);
    prog[7]  = enc_i(6'b000111, 1, 2, 3);
    prog[8]  = enc_i(6'b000101, 0, 0, 3);
    prog[9]  = enc_i(6'b000001, 3, 0, 3);
    prog[10] = enc_i(6'b000111, 3, 1, 1);
    prog[11] = enc_i(6'b001000, 0, 9, 'h99);
    prog[12] = enc_i(6'b000001, 1, 0, 1);
    load_and_reset();
    step(4);
    step_pc(32'h1C);
    step_pc(32'h20);
    step_pc(32'h24);
    step_pc(32'h28);
    step_pc(32'h30);
    step_pc(32'h38);
    exp_reg(9, 32'd0);
    check_all();

    // Jumps, including fetch wrap past the end of IM
    clear_prog();
    prog[0]  = enc_i(6'b001000, 6, 6, 1);
    prog[2]  = enc_j(6'b000011, 'h10);
    prog[3]  = enc_j(6'b000010, 'h05);
    prog[5]  = enc_j(6'b000010, 'h20);
    prog[16] = enc_r(31, 0, 0, 0, 6'b001000);
    load_and_reset();
    step_pc(32'h04);
    step_pc(32'h08);
    step_pc(32'h40);
    exp_reg(31, 32'h0C);
    check_all();
    step_pc(32'h0C);
    step_pc(32'h14);
    step_pc(32'h80);
    step_pc(32'h84);
    exp_reg(6, 32'd2);
    check_all();

    // Misc: ori, lui, mul, unknown opcode / funct
    clear_prog();
    prog[0] = enc_i(6'b001000, 0, 3, 7);
    prog[1] = enc_i(6'b001101, 0, 1, 'hFFFF);
    prog[2] = enc_i(6'b001111, 0, 2, 'h8000);
    prog[3] = enc_r(1, 1, 3, 0, 6'b011000);
    prog[4] = 32'hFFFF_FFFF;
    prog[5] = enc_r(1, 1, 1, 0, 6'b111111);
    load_and_reset();
    step(6);
    exp_reg(1, 32'h0000_FFFF);
    exp_reg(2, 32'h0000_8000);
`ifdef MUL_EN
    exp_reg(3, 32'hFFFE_0001);
`else
    exp_reg(3, 32'd7);
`endif
    exp_reg(31, 32'd0);
    exp_pc(32'h18);
    check_all();

    // Memory, r0 write discard, address wrap and alignment
    clear_prog();
    prog[0] = enc_i(6'b001000, 0, 1, 'h1234);
    prog[1] = enc_i(6'b101011, 29, 1, -4);
    prog[2] = enc_i(6'b100011, 29, 2, -4);
    prog[3] = enc_i(6'b001000, 0, 0, 7);
    prog[4] = enc_i(6'b101011, 29, 1, 4);
    prog[5] = enc_i(6'b100011, 0, 3, 6);
    load_and_reset();
    step(6);
    exp_mem(31, 32'h1234);
    exp_reg(2, 32'h1234);
    exp_reg(0, 32'd0);
    exp_mem(1, 32'h1234);
    exp_reg(3, 32'h1234);
    exp_pc(32'h18);
    check_all();

    // Reset clears the state left by the memory program
    load_and_reset();
    exp_pc(32'd0);
    exp_mem(31, 32'd0);
    exp_mem(1, 32'd0);
    exp_reg(2, 32'd0);
    exp_reg(29, 32'd128);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
